// File: rtl/jsv_pkg.sv
// rtl/jsv_pkg.sv - shared register map, control bits and FSM states for jsv_param_ctrl
package jsv_pkg;

  // Avalon-MM word offsets
  localparam logic [1:0] ADDR_CRE   = 2'd0;
  localparam logic [1:0] ADDR_CIM   = 2'd1;
  localparam logic [1:0] ADDR_SCALE = 2'd2;
  localparam logic [1:0] ADDR_CTRL  = 2'd3;

  // Control register bit positions
  localparam int CTRL_COMMIT_BIT = 0;
  localparam int CTRL_RUN_BIT    = 1;
  localparam int CTRL_CLR_BIT    = 2;
  localparam int CTRL_BUSY_BIT   = 2;

  // Frame sequencing states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_START = 2'd2,
    ST_BUSY  = 2'd3
  } state_e;

endpackage

// File: rtl/jsv_param_ctrl.sv
// rtl/jsv_param_ctrl.sv - Julia-set parameter register file and frame sequencer
module jsv_param_ctrl
  import jsv_pkg::*;
#(
  parameter int FCNT_W      = 16,
  parameter bit RUN_DEFAULT = 1'b0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [31:0] c_re,
  output logic [31:0] c_im,
  output logic [31:0] scale,
  output logic        frame_start,
  input  logic        frame_ack,
  input  logic        frame_done
);

  state_e state_q, state_d;

  logic [31:0]       shadow_cre_q, shadow_cim_q, shadow_scale_q;
  logic [31:0]       active_cre_q, active_cim_q, active_scale_q;
  logic              commit_q;
  logic              run_q;
  logic [FCNT_W-1:0] frame_cnt_q;
  logic [15:0]       cnt_ext;

  logic wr_en;
  logic ctrl_wr;
  logic busy;

  assign wr_en   = chipselect & ~write_n;
  assign ctrl_wr = wr_en && (address == ADDR_CTRL);
  assign busy    = (state_q != ST_IDLE);
  assign cnt_ext = 16'(frame_cnt_q);

  // The engine only ever sees values latched in LOAD, so shadow edits are safe mid-frame
  assign c_re        = active_cre_q;
  assign c_im        = active_cim_q;
  assign scale       = active_scale_q;
  assign frame_start = (state_q == ST_START);

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic: acks and done pulses only matter in the state that expects them
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (commit_q || run_q) state_d = ST_LOAD;
      ST_LOAD:  state_d = ST_START;
      ST_START: if (frame_ack) state_d = ST_BUSY;
      ST_BUSY: begin
        if (frame_done) state_d = (commit_q || run_q) ? ST_LOAD : ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  // Shadow parameter registers, written from the bus in any state
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      shadow_cre_q   <= '0;
      shadow_cim_q   <= '0;
      shadow_scale_q <= '0;
    end else if (wr_en) begin
      case (address)
        ADDR_CRE:   shadow_cre_q   <= writedata;
        ADDR_CIM:   shadow_cim_q   <= writedata;
        ADDR_SCALE: shadow_scale_q <= writedata;
        default:    ;
      endcase
    end
  end

  // Active parameters copy the shadows only while in LOAD
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      active_cre_q   <= '0;
      active_cim_q   <= '0;
      active_scale_q <= '0;
    end else if (state_q == ST_LOAD) begin
      active_cre_q   <= shadow_cre_q;
      active_cim_q   <= shadow_cim_q;
      active_scale_q <= shadow_scale_q;
    end
  end

  // Control bits: a commit write beats the LOAD clear so a second load is queued
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      commit_q <= 1'b0;
      run_q    <= RUN_DEFAULT;
    end else begin
      if (ctrl_wr && writedata[CTRL_COMMIT_BIT]) commit_q <= 1'b1;
      else if (state_q == ST_LOAD)               commit_q <= 1'b0;
      if (ctrl_wr) run_q <= writedata[CTRL_RUN_BIT];
    end
  end

  // Completed-frame counter; a clear request wins over a coincident increment
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      frame_cnt_q <= '0;
    end else if (ctrl_wr && writedata[CTRL_CLR_BIT]) begin
      frame_cnt_q <= '0;
    end else if ((state_q == ST_BUSY) && frame_done) begin
      frame_cnt_q <= frame_cnt_q + FCNT_W'(1);
    end
  end

  // Zero-wait-state read mux
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_CRE:   readdata = shadow_cre_q;
      ADDR_CIM:   readdata = shadow_cim_q;
      ADDR_SCALE: readdata = shadow_scale_q;
      ADDR_CTRL: begin
        readdata[31:16]           = cnt_ext;
        readdata[CTRL_BUSY_BIT]   = busy;
        readdata[CTRL_RUN_BIT]    = run_q;
        readdata[CTRL_COMMIT_BIT] = commit_q;
      end
      default:    readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_jsv_param_ctrl.sv
// tb/tb_jsv_param_ctrl.sv - directed self-checking bench for jsv_param_ctrl
module tb_jsv_param_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [31:0] c_re, c_im, scale;
  logic        frame_start;
  logic        frame_ack;
  logic        frame_done;

  int n_tests = 0;
  int n_fail  = 0;
  int n_starts = 0;
  logic [31:0] rv;

  jsv_param_ctrl #(.FCNT_W(8), .RUN_DEFAULT(1'b0)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .c_re       (c_re),
    .c_im       (c_im),
    .scale      (scale),
    .frame_start(frame_start),
    .frame_ack  (frame_ack),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    cyc();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    address = a;
    #1;
    d = readdata;
  endtask

  task automatic do_frame(input string tag);
    for (int k = 0; k < 20 && !frame_start; k++) cyc();
    chk({tag, "_start"}, {31'b0, frame_start}, 32'd1);
    if (frame_start) n_starts++;
    frame_ack = 1'b1;
    cyc();
    frame_ack  = 1'b0;
    frame_done = 1'b1;
    cyc();
    frame_done = 1'b0;
  endtask

  initial begin
    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    frame_ack  = 1'b0;
    frame_done = 1'b0;
    repeat (3) cyc();
    reset_n = 1'b1;

    rd(2'd3, rv); chk("rst_ctrl", rv, 32'h0000_0000);
    chk("rst_cre", c_re, 32'h0);
    chk("rst_cim", c_im, 32'h0);
    chk("rst_scale", scale, 32'h0);
    chk("rst_fs", {31'b0, frame_start}, 32'd0);

    wr(2'd0, 32'h3F00_0000);
    wr(2'd1, 32'hBE80_0000);
    wr(2'd2, 32'h3B80_0000);
    rd(2'd1, rv); chk("shadow_cim", rv, 32'hBE80_0000);
    chk("act_before_commit", c_re, 32'h0);
    wr(2'd3, 32'h1);
    rd(2'd3, rv); chk("commit_pending", rv, 32'h0000_0001);
    cyc();
    rd(2'd3, rv); chk("in_load", rv, 32'h0000_0005);
    chk("load_cre_not_yet", c_re, 32'h0);
    cyc();
    chk("start_cre", c_re, 32'h3F00_0000);
    chk("start_cim", c_im, 32'hBE80_0000);
    chk("start_scale", scale, 32'h3B80_0000);
    chk("start_fs", {31'b0, frame_start}, 32'd1);
    rd(2'd3, rv); chk("start_ctrl", rv, 32'h0000_0004);

    repeat (5) cyc();
    chk("fs_hold", {31'b0, frame_start}, 32'd1);
    frame_ack = 1'b1;
    cyc();
    frame_ack = 1'b0;
    chk("fs_after_ack", {31'b0, frame_start}, 32'd0);
    rd(2'd3, rv); chk("busy_ctrl", rv, 32'h0000_0004);

    wr(2'd0, 32'h4000_0000);
    chk("busy_cre_held", c_re, 32'h3F00_0000);
    repeat (18) cyc();
    frame_done = 1'b1;
    cyc();
    frame_done = 1'b0;
    rd(2'd3, rv); chk("frame1_cnt", rv, 32'h0001_0000);
    chk("idle_cre_held", c_re, 32'h3F00_0000);

    wr(2'd3, 32'h1);
    cyc();
    cyc();
    chk("reload_cre", c_re, 32'h4000_0000);
    frame_ack = 1'b1;
    cyc();
    frame_ack  = 1'b0;
    frame_done = 1'b1;
    cyc();
    frame_done = 1'b0;
    rd(2'd3, rv); chk("frame2_cnt", rv, 32'h0002_0000);

    wr(2'd3, 32'h4);
    rd(2'd3, rv); chk("cnt_clear", rv, 32'h0000_0000);

    wr(2'd3, 32'h2);
    n_starts = 0;
    for (int i = 0; i < 255; i++) do_frame("run");
    rd(2'd3, rv); chk("cnt_255", rv, 32'h00FF_0006);
    do_frame("run_last");
    rd(2'd3, rv); chk("cnt_wrap", rv, 32'h0000_0006);
    chk("starts_256", n_starts, 32'd256);

    for (int k = 0; k < 20 && !frame_start; k++) cyc();
    chk("run_mid_start", {31'b0, frame_start}, 32'd1);
    frame_ack = 1'b1;
    cyc();
    frame_ack = 1'b0;
    wr(2'd3, 32'h0);
    rd(2'd3, rv); chk("run_cleared_busy", rv, 32'h0000_0004);
    frame_done = 1'b1;
    cyc();
    frame_done = 1'b0;
    repeat (3) cyc();
    rd(2'd3, rv); chk("run_stop_idle", rv, 32'h0001_0000);
    chk("run_stop_fs", {31'b0, frame_start}, 32'd0);

    frame_done = 1'b1;
    cyc();
    frame_done = 1'b0;
    frame_ack = 1'b1;
    cyc();
    frame_ack = 1'b0;
    rd(2'd3, rv); chk("stray_ignored", rv, 32'h0001_0000);

    wr(2'd3, 32'h1);
    cyc();
    wr(2'd3, 32'h1);
    rd(2'd3, rv); chk("commit_in_load", rv, 32'h0001_0005);
    frame_ack = 1'b1;
    cyc();
    frame_ack  = 1'b0;
    frame_done = 1'b1;
    cyc();
    frame_done = 1'b0;
    cyc();
    rd(2'd3, rv); chk("second_load", rv, 32'h0002_0004);
    frame_ack = 1'b1;
    cyc();
    frame_ack  = 1'b0;
    frame_done = 1'b1;
    cyc();
    frame_done = 1'b0;
    rd(2'd3, rv); chk("after_second", rv, 32'h0003_0000);

    wr(2'd3, 32'h1);
    cyc();
    cyc();
    frame_ack = 1'b1;
    cyc();
    frame_ack  = 1'b0;
    frame_done = 1'b1;
    wr(2'd3, 32'h4);
    frame_done = 1'b0;
    rd(2'd3, rv); chk("clr_wins", rv, 32'h0000_0000);

    wr(2'd3, 32'h1);
    cyc();
    cyc();
    frame_ack = 1'b1;
    cyc();
    frame_ack = 1'b0;
    rd(2'd3, rv); chk("pre_reset_busy", rv, 32'h0000_0004);
    reset_n = 1'b0;
    cyc();
    reset_n    = 1'b1;
    frame_done = 1'b1;
    cyc();
    frame_done = 1'b0;
    cyc();
    rd(2'd3, rv); chk("reset_mid_cnt", rv, 32'h0000_0000);
    chk("reset_mid_fs", {31'b0, frame_start}, 32'd0);
    chk("reset_mid_cre", c_re, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/jsv_param_ctrl.md
JSV_PARAM_CTRL -- requirements
Module: jsv_param_ctrl

Interface
REQ-001 SHALL have parameter FCNT_W, default 16: frame-counter width, legal range 8..16.
REQ-002 SHALL have parameter RUN_DEFAULT, default 0: reset value of the continuous-run bit.
REQ-003 SHALL use one clock; reset is synchronous and active-low.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset_n  input  1  synchronous active-low reset.
REQ-006 address  input  2  Avalon-MM slave word address.
REQ-007 chipselect  input  1  slave select.
REQ-008 write_n  input  1  active-low write strobe.
REQ-009 writedata  input  32  write data.
REQ-010 readdata  output  32  read data, zero wait states.
REQ-011 c_re  output  32  active Julia constant, real part, IEEE-754 single.
REQ-012 c_im  output  32  active Julia constant, imaginary part, IEEE-754 single.
REQ-013 scale  output  32  active pixel-step scale, IEEE-754 single.
REQ-014 frame_start  output  1  request to the fractal engine to render one frame.
REQ-015 frame_ack  input  1  engine accepted frame_start.
REQ-016 frame_done  input  1  one-cycle pulse: engine finished the frame.

Function
REQ-017 Write strobe = chipselect & ~write_n; address 0/1/2 writes shadow c_re/c_im/scale; opaque bit patterns, no float arithmetic.
REQ-018 Address 3 write: bit0 = 1 sets commit_pending; bit1 loads run; bit2 = 1 clears frame counter; other bits ignored.
REQ-019 readdata combinational from address: 0/1/2 -> shadow registers; 3 -> {frame_cnt zero-extended in [31:16], 13'b0, busy[2], run[1], commit_pending[0]}.
REQ-020 Active outputs c_re/c_im/scale SHALL change only in state LOAD, never while frame_start or the engine frame is in progress.
REQ-021 FSM states IDLE, LOAD, START, BUSY; busy = (state != IDLE).
REQ-022 IDLE -> LOAD when commit_pending or run; else hold.
REQ-023 LOAD (exactly 1 cycle): copy all three shadows to active, clear commit_pending, -> START.
REQ-024 START: frame_start = 1; hold until frame_ack = 1, then -> BUSY; frame_start deasserts the cycle after ack is sampled.
REQ-025 BUSY: on frame_done increment frame_cnt (mod 2^FCNT_W, wraps to 0) and -> LOAD if commit_pending or run, else IDLE.
REQ-026 frame_done outside BUSY SHALL be ignored; frame_ack outside START SHALL be ignored.
REQ-027 Commit write during LOAD SHALL leave commit_pending set (set wins over LOAD clear) so a second load follows.
REQ-028 Shadow writes in any state SHALL not disturb active outputs until the next LOAD.
REQ-029 Counter-clear write coinciding with frame_done SHALL leave frame_cnt = 0 (clear wins).
REQ-030 Clearing run while BUSY SHALL let the current frame finish, then IDLE (unless commit_pending).

Reset
REQ-031 While reset_n = 0 at a rising edge: state = IDLE, shadows and active c_re/c_im/scale = 0, frame_start = 0, commit_pending = 0, run = RUN_DEFAULT, frame_cnt = 0.
REQ-032 Reset mid-frame SHALL abandon the frame; post-reset frame_done pulses are ignored per REQ-026.

Structure
REQ-033 State encoding enum and register offsets (ADDR_CRE=0, ADDR_CIM=1, ADDR_SCALE=2, ADDR_CTRL=3) and control bit positions SHALL live in shared package jsv_pkg.
REQ-034 Single module; Avalon register file and FSM in one file, no sub-modules.

Verification
REQ-035 Reset, read address 3 -> 0x00000000 (RUN_DEFAULT=0); outputs all zero.
REQ-036 Write c_re=0x3F000000, c_im=0xBE800000, scale=0x3B800000, ctrl=0x1 -> active values appear 1 cycle after LOAD; frame_start high until ack; commit_pending reads 0.
REQ-037 Ack after 5 cycles, frame_done after 20 -> frame_cnt reads 1 (0x00010000 at address 3, busy=0), state IDLE.
REQ-038 Write c_re=0x40000000 while BUSY -> c_re output unchanged until after frame_done, then 0x40000000.
REQ-039 run=1, FCNT_W=8, 256 frames -> frame_cnt wraps to 0; frame_start reasserted each frame; clear run mid-frame -> IDLE after that frame.
REQ-040 Assert reset_n=0 in BUSY, then frame_done pulse -> frame_cnt stays 0, frame_start stays 0.
